// File: rtl/bus_ep_pkg.sv
// Shared types and helpers for the bus device endpoint: ID width, broadcast
// default and destination-ID extraction from a packet.
package bus_ep_pkg;

  localparam int ID_W        = 8;
  localparam int MAX_PCKG_SZ = 64;
  localparam int MAX_IDX_W   = 6;
  localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;

  // Packets are right-aligned in a MAX_PCKG_SZ container; the ID is the top
  // ID_W bits of the real packet width.
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PCKG_SZ-1:0] pkt,
                                              input int                     pckg_sz);
    logic [MAX_IDX_W-1:0] msb;
    msb = MAX_IDX_W'(pckg_sz - 1);
    return pkt[msb -: ID_W];
  endfunction

endpackage

// File: rtl/bus_dev_endpoint_if.sv
// Host and bus-arbiter signal bundle of the endpoint. Handshakes: a transfer
// happens on a rising edge where valid/pop/push and its qualifying ready are both 1.
interface bus_dev_endpoint_if #(
  parameter int PCKG_SZ = 24
);

  logic               tx_valid;
  logic [PCKG_SZ-1:0] tx_data;
  logic               tx_ready;
  logic               pndng;
  logic [PCKG_SZ-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [PCKG_SZ-1:0] D_push;
  logic               rx_valid;
  logic [PCKG_SZ-1:0] rx_data;
  logic               rx_ready;
  logic [7:0]         rx_drop_cnt;
  logic [7:0]         rx_misroute_cnt;
  logic               pop_err;

  modport master (
    output tx_valid, tx_data, pop, push, D_push, rx_ready,
    input  tx_ready, pndng, D_pop, rx_valid, rx_data,
           rx_drop_cnt, rx_misroute_cnt, pop_err
  );

  modport slave (
    input  tx_valid, tx_data, pop, push, D_push, rx_ready,
    output tx_ready, pndng, D_pop, rx_valid, rx_data,
           rx_drop_cnt, rx_misroute_cnt, pop_err
  );

endinterface

// File: rtl/ep_fifo.sv
// First-word-fall-through FIFO with registered empty/full flags. DEPTH must be
// a power of two so the pointers wrap by plain overflow.
module ep_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd,
  output logic [W-1:0] o_rd_data,
  output logic         o_not_empty,
  output logic         o_not_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_not_empty;
  logic          r_not_full;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_count_nxt;

  // Full/empty are the registered flags from the previous edge, so a write
  // while full is refused even when a read frees a slot in the same cycle.
  assign w_wr_ok = i_wr & r_not_full;
  assign w_rd_ok = i_rd & r_not_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_not_empty <= 1'b0;
      r_not_full  <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count     <= w_count_nxt;
      r_not_empty <= (w_count_nxt != '0);
      r_not_full  <= (w_count_nxt != FULL_CNT);
    end
  end

  // Storage carries no reset; its contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (reset && w_wr_ok) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  assign o_rd_data   = r_mem[r_rptr];
  assign o_not_empty = r_not_empty;
  assign o_not_full  = r_not_full;

endmodule

// File: rtl/bus_dev_endpoint.sv
// Bus device endpoint: a TX FIFO feeding the bus arbiter and an ID-filtered
// RX FIFO feeding the host, with saturating drop/misroute counters.
module bus_dev_endpoint
  import bus_ep_pkg::*;
#(
  parameter int              PCKG_SZ  = 24,
  parameter int              DEPTH    = 8,
  parameter logic [ID_W-1:0] DEV_ID   = '0,
  parameter logic [ID_W-1:0] BCAST_ID = BCAST_ID_DEF
) (
  input  logic               clk,
  input  logic               reset,
  bus_dev_endpoint_if.slave  bus
);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic                   w_tx_not_empty;
  logic                   w_tx_not_full;
  logic                   w_rx_not_empty;
  logic                   w_rx_not_full;
  logic [MAX_PCKG_SZ-1:0] w_push_ext;
  logic [ID_W-1:0]        w_push_id;
  logic                   w_id_match;
  logic                   w_rx_accept;
  logic                   w_rx_drop;
  logic                   w_misroute;

  logic [7:0]             r_drop_cnt;
  logic [7:0]             r_misroute_cnt;
  logic                   r_pop_err;

  ep_fifo #(
    .W     (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_wr        (bus.tx_valid),
    .i_wr_data   (bus.tx_data),
    .i_rd        (bus.pop),
    .o_rd_data   (bus.D_pop),
    .o_not_empty (w_tx_not_empty),
    .o_not_full  (w_tx_not_full)
  );

  always_comb begin
    w_push_ext                = '0;
    w_push_ext[PCKG_SZ-1:0]   = bus.D_push;
  end

  assign w_push_id   = dest_id(w_push_ext, PCKG_SZ);
  assign w_id_match  = (w_push_id == DEV_ID) || (w_push_id == BCAST_ID);
  assign w_rx_accept = bus.push & w_id_match;
  assign w_rx_drop   = w_rx_accept & ~w_rx_not_full;
  assign w_misroute  = bus.push & ~w_id_match;

  ep_fifo #(
    .W     (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_wr        (w_rx_accept),
    .i_wr_data   (bus.D_push),
    .i_rd        (bus.rx_ready),
    .o_rd_data   (bus.rx_data),
    .o_not_empty (w_rx_not_empty),
    .o_not_full  (w_rx_not_full)
  );

  // Counters stick at CNT_MAX; pop_err stays set until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt     <= '0;
      r_misroute_cnt <= '0;
      r_pop_err      <= 1'b0;
    end else begin
      if (w_rx_drop && (r_drop_cnt != CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_misroute && (r_misroute_cnt != CNT_MAX)) begin
        r_misroute_cnt <= r_misroute_cnt + 1'b1;
      end
      if (bus.pop && !w_tx_not_empty) begin
        r_pop_err <= 1'b1;
      end
    end
  end

  assign bus.tx_ready        = w_tx_not_full;
  assign bus.pndng           = w_tx_not_empty;
  assign bus.rx_valid        = w_rx_not_empty;
  assign bus.rx_drop_cnt     = r_drop_cnt;
  assign bus.rx_misroute_cnt = r_misroute_cnt;
  assign bus.pop_err         = r_pop_err;

endmodule
